// File: rtl/sseg_pkg.sv
// Shared types and constants for the 4-digit multiplexed seven-segment driver.
package sseg_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [3:0] AN_OFF     = 4'b1111;
    localparam logic       DP_OFF     = 1'b1;

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    typedef logic [1:0] digit_idx_t;

    // One complete display image: nibbles, decimal points and digit enables.
    typedef struct packed {
        logic [15:0]           value;
        logic [NUM_DIGITS-1:0] dp;
        logic [NUM_DIGITS-1:0] en;
    } disp_t;

    function automatic logic [3:0] nibble(input logic [15:0] v, input digit_idx_t i);
        return v[{i, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] an_onehot(input digit_idx_t i);
        logic [3:0] one;
        one = 4'b0001 << i;
        return ~one;
    endfunction

endpackage

// File: rtl/sseg_scan_mux_if.sv
// Display data in, multiplexed digit drive out.
interface sseg_scan_mux_if;
    import sseg_pkg::*;

    logic [15:0]           value;
    logic [NUM_DIGITS-1:0] dp_in;
    logic [NUM_DIGITS-1:0] digit_en;
    logic                  load;
    logic [3:0]            hex;
    logic [NUM_DIGITS-1:0] an;
    logic                  dp;
    logic                  frame_done;

    modport master (
        output value, dp_in, digit_en, load,
        input  hex, an, dp, frame_done
    );

    modport slave (
        input  value, dp_in, digit_en, load,
        output hex, an, dp, frame_done
    );

endinterface

// File: rtl/sseg_refresh_timer.sv
// Slot prescaler and digit index; emits slot/show/frame ticks for the scan FSM.
module sseg_refresh_timer
    import sseg_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    output digit_idx_t idx,
    output logic       slot_end,
    output logic       show_start,
    output logic       frame_end
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST    = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] SHOW_AT = CW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);

    if (REFRESH_DIV < 2 || BLANK_CYCLES < 0 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_param
        $error("sseg_refresh_timer: need REFRESH_DIV >= 2 and 0 <= BLANK_CYCLES < REFRESH_DIV");
    end

    logic [CW-1:0] cnt;

    assign slot_end   = (cnt == LAST);
    // With no blanking the FSM never leaves ST_SHOW, so no show tick is needed.
    assign show_start = (BLANK_CYCLES != 0) && (cnt == SHOW_AT);
    assign frame_end  = slot_end && (idx == digit_idx_t'(NUM_DIGITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sseg_scan_mux.sv
// Time-multiplexes a 16-bit value over a 4-digit common-anode display with
// frame-synchronous (tear-free) updates and inter-digit blanking.
module sseg_scan_mux
    import sseg_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic            clk,
    input  logic            rst_n,
    sseg_scan_mux_if.slave  bus
);

    // Without blanking every slot is entirely visible from the first cycle.
    localparam state_t ST_INIT = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;

    digit_idx_t idx;
    logic       slot_end, show_start, frame_end;

    sseg_refresh_timer #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .idx        (idx),
        .slot_end   (slot_end),
        .show_start (show_start),
        .frame_end  (frame_end)
    );

    disp_t  incoming, staging, shadow;
    logic   pending;
    state_t state;

    logic [3:0]            hex_q;
    logic [NUM_DIGITS-1:0] an_q;
    logic                  dp_q;
    logic                  frame_done_q;

    assign incoming = '{value: bus.value, dp: bus.dp_in, en: bus.digit_en};

    // A load landing on the boundary cycle goes straight to the shadow so it
    // is not held back a whole extra frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staging <= '0;
            shadow  <= '0;
            pending <= 1'b0;
        end else if (bus.load && frame_end) begin
            shadow  <= incoming;
            pending <= 1'b0;
        end else if (bus.load) begin
            staging <= incoming;
            pending <= 1'b1;
        end else if (frame_end && pending) begin
            shadow  <= staging;
            pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_INIT;
            hex_q        <= 4'h0;
            an_q         <= AN_OFF;
            dp_q         <= DP_OFF;
            frame_done_q <= 1'b0;
        end else begin
            // hex tracks the slot digit even while blanked so the decoder settles early.
            hex_q        <= nibble(shadow.value, idx);
            frame_done_q <= frame_end;
            if (state == ST_SHOW && shadow.en[idx]) begin
                an_q <= an_onehot(idx);
                dp_q <= ~shadow.dp[idx];
            end else begin
                an_q <= AN_OFF;
                dp_q <= DP_OFF;
            end
            case (state)
                ST_BLANK: if (show_start) state <= ST_SHOW;
                ST_SHOW:  if (slot_end && BLANK_CYCLES != 0) state <= ST_BLANK;
                default:  state <= ST_INIT;
            endcase
        end
    end

    assign bus.hex        = hex_q;
    assign bus.an         = an_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Directed bench for sseg_scan_mux with REFRESH_DIV=8, BLANK_CYCLES=2 (32-cycle frames).
module tb_sseg_scan_mux;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    sseg_scan_mux_if bus ();

    sseg_scan_mux #(
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for sample j (0..31) of a frame: slot j/8, count j%8.
    function automatic logic [3:0] exp_an(input int j, input logic [3:0] en);
        logic [3:0] one;
        int s;
        s   = j / 8;
        one = 4'b0001 << s;
        if ((j % 8) < 2 || !en[s]) return 4'b1111;
        return ~one;
    endfunction

    function automatic logic [3:0] exp_hex(input int j, input logic [15:0] v);
        return v[4*(j/8) +: 4];
    endfunction

    function automatic logic exp_dp(input int j, input logic [3:0] en, input logic [3:0] dpr);
        int s;
        s = j / 8;
        return !((j % 8) >= 2 && en[s] && dpr[s]);
    endfunction

    // Advances until frame_done is seen; n = samples taken, 0 on timeout.
    task automatic wait_fd(output int n);
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (bus.frame_done === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] en, input logic [3:0] dpr);
        bus.value    = v;
        bus.digit_en = en;
        bus.dp_in    = dpr;
        bus.load     = 1'b1;
        @(posedge clk); #1;
        bus.load     = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #20;
        checks++;
        if ({bus.an, bus.dp, bus.hex, bus.frame_done} !== {4'b1111, 1'b1, 4'h0, 1'b0}) begin
            failures++;
            $display("FAIL reset_init got an=%b dp=%b hex=%h fd=%b exp an=1111 dp=1 hex=0 fd=0",
                     bus.an, bus.dp, bus.hex, bus.frame_done);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_load(16'h1A2F, 4'b1111, 4'b1111);
        wait_fd(n);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
        end
        checks++;
        if ({bus.an, bus.dp, bus.hex} !== {4'b1110, 1'b0, 4'hF}) begin
            failures++;
            $display("FAIL reset_pre_show got an=%b dp=%b hex=%h exp an=1110 dp=0 hex=f",
                     bus.an, bus.dp, bus.hex);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.an, bus.dp, bus.hex, bus.frame_done} !== {4'b1111, 1'b1, 4'h0, 1'b0}) begin
            failures++;
            $display("FAIL reset_async got an=%b dp=%b hex=%h fd=%b exp an=1111 dp=1 hex=0 fd=0",
                     bus.an, bus.dp, bus.hex, bus.frame_done);
        end
        #2 rst_n = 1'b1;
        wait_fd(n);
        checks++;
        if (n !== 32) begin
            failures++;
            $display("FAIL reset_first_frame got %0d cycles exp 32", n);
        end
    endtask

    task automatic test_basic_scan();
        int n;
        do_load(16'h1A2F, 4'b1111, 4'b0000);
        wait_fd(n);
        checks++;
        if (n !== 31) begin
            failures++;
            $display("FAIL basic_period got %0d exp 31", n);
        end
        for (int j = 0; j < 32; j++) begin
            @(posedge clk); #1;
            checks++;
            if ({bus.an, bus.hex, bus.dp, bus.frame_done} !==
                {exp_an(j, 4'b1111), exp_hex(j, 16'h1A2F), 1'b1, j == 31}) begin
                failures++;
                $display("FAIL basic_scan j=%0d got an=%b hex=%h dp=%b fd=%b exp an=%b hex=%h dp=1 fd=%b",
                         j, bus.an, bus.hex, bus.dp, bus.frame_done,
                         exp_an(j, 4'b1111), exp_hex(j, 16'h1A2F), j == 31);
            end
        end
    endtask

    task automatic test_digit_en();
        int n;
        do_load(16'h1A2F, 4'b0101, 4'b0000);
        wait_fd(n);
        checks++;
        if (n !== 31) begin
            failures++;
            $display("FAIL digit_en_period got %0d exp 31", n);
        end
        for (int j = 0; j < 32; j++) begin
            @(posedge clk); #1;
            checks++;
            if ({bus.an, bus.hex, bus.dp, bus.frame_done} !==
                {exp_an(j, 4'b0101), exp_hex(j, 16'h1A2F), 1'b1, j == 31}) begin
                failures++;
                $display("FAIL digit_en j=%0d got an=%b hex=%h dp=%b fd=%b exp an=%b hex=%h dp=1 fd=%b",
                         j, bus.an, bus.hex, bus.dp, bus.frame_done,
                         exp_an(j, 4'b0101), exp_hex(j, 16'h1A2F), j == 31);
            end
        end
    endtask

    task automatic test_tear_free();
        int n;
        do_load(16'h1111, 4'b1111, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
        end
        do_load(16'h2222, 4'b1111, 4'b0000);
        wait_fd(n);
        checks++;
        if (n !== 27) begin
            failures++;
            $display("FAIL tear_period got %0d exp 27", n);
        end
        for (int j = 0; j < 32; j++) begin
            @(posedge clk); #1;
            checks++;
            if ({bus.an, bus.hex, bus.frame_done} !== {exp_an(j, 4'b1111), 4'h2, j == 31}) begin
                failures++;
                $display("FAIL tear_free j=%0d got an=%b hex=%h fd=%b exp an=%b hex=2 fd=%b",
                         j, bus.an, bus.hex, bus.frame_done, exp_an(j, 4'b1111), j == 31);
            end
        end
    endtask

    task automatic test_boundary();
        for (int k = 0; k < 31; k++) begin
            @(posedge clk); #1;
        end
        do_load(16'h3C3C, 4'b1111, 4'b0000);
        checks++;
        if (bus.frame_done !== 1'b1) begin
            failures++;
            $display("FAIL boundary_align got fd=%b exp 1", bus.frame_done);
        end
        for (int f = 0; f < 2; f++) begin
            for (int j = 0; j < 32; j++) begin
                @(posedge clk); #1;
                checks++;
                if ({bus.an, bus.hex, bus.frame_done} !==
                    {exp_an(j, 4'b1111), exp_hex(j, 16'h3C3C), j == 31}) begin
                    failures++;
                    $display("FAIL boundary f=%0d j=%0d got an=%b hex=%h fd=%b exp an=%b hex=%h fd=%b",
                             f, j, bus.an, bus.hex, bus.frame_done,
                             exp_an(j, 4'b1111), exp_hex(j, 16'h3C3C), j == 31);
                end
            end
        end
    endtask

    task automatic test_dp();
        int n;
        do_load(16'h3C3C, 4'b1111, 4'b1000);
        wait_fd(n);
        checks++;
        if (n !== 31) begin
            failures++;
            $display("FAIL dp_period got %0d exp 31", n);
        end
        for (int f = 0; f < 2; f++) begin
            for (int j = 0; j < 32; j++) begin
                @(posedge clk); #1;
                checks++;
                if ({bus.an, bus.dp, bus.frame_done} !==
                    {exp_an(j, 4'b1111), exp_dp(j, 4'b1111, 4'b1000), j == 31}) begin
                    failures++;
                    $display("FAIL dp f=%0d j=%0d got an=%b dp=%b fd=%b exp an=%b dp=%b fd=%b",
                             f, j, bus.an, bus.dp, bus.frame_done,
                             exp_an(j, 4'b1111), exp_dp(j, 4'b1111, 4'b1000), j == 31);
                end
            end
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        bus.value    = '0;
        bus.dp_in    = '0;
        bus.digit_en = '0;
        bus.load     = 1'b0;
        test_reset();
        test_basic_scan();
        test_digit_en();
        test_tear_free();
        test_boundary();
        test_dp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sseg_scan_mux.md
Name: sseg_scan_mux

Overview:
- Upstream neighbour of the single-digit hex-to-segment decoder. Time-multiplexes a 16-bit value across the 4-digit common-anode display.
- Each cycle it presents one nibble on hex (wired to the decoder input), drives the active-low anode, and drives the active-low decimal point.
- New display data is staged through a load strobe and committed only at frame boundaries, so the display never shows a torn value.
- Inter-digit blanking suppresses ghosting.

Parameters:
- REFRESH_DIV, 50000, clock cycles per digit slot. Constraint: REFRESH_DIV >= 2.
- BLANK_CYCLES, 500, cycles at the start of each slot with all anodes off. Constraint: 0 <= BLANK_CYCLES < REFRESH_DIV.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- value  in  16  display data; digit i = value[4i+3:4i]
- dp_in  in  4  decimal point request per digit, 1 = lit
- digit_en  in  4  per-digit enable, 1 = digit shown
- load  in  1  single-cycle strobe; captures value/dp_in/digit_en into the staging register
- hex  out  4  nibble for the current slot, feeds the decoder
- an  out  4  anode select, active-low one-hot
- dp  out  1  decimal point, active-low
- frame_done  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (asserted at any time, including mid-slot):
  - Outputs: an=4'b1111, dp=1, hex=4'h0, frame_done=0.
  - Internal state: slot counter=0, digit index=0, state=ST_BLANK, shadow and staging registers all zero, pending=0.
- First slot after reset release: counts from 0 in ST_BLANK. With BLANK_CYCLES=0 it starts in ST_SHOW.
- Slot timing:
  - Counter runs 0..REFRESH_DIV-1.
  - Count 0..BLANK_CYCLES-1 is ST_BLANK; remaining counts are ST_SHOW.
  - At count REFRESH_DIV-1: counter wraps to 0 and index increments 0->1->2->3->0.
- State machine:
  - ST_BLANK -> ST_SHOW when count reaches BLANK_CYCLES-1.
  - ST_SHOW -> ST_BLANK at slot end; stays in ST_SHOW when BLANK_CYCLES=0.
- Output registration and latency:
  - All outputs are registered.
  - Output values correspond to the internal counter/index/state of the previous cycle (1-cycle latency).
- Outputs per state:
  - hex = shadow nibble[index] throughout the slot, in both states, so the decoder is settled before the anode turns on.
  - an in ST_BLANK = 4'b1111.
  - an in ST_SHOW = ~(1<<index) if shadow_en[index], else 4'b1111.
  - dp = ~shadow_dp[index] in ST_SHOW with the digit enabled; otherwise 1.
- Frame boundary: the last cycle of slot 3.
  - frame_done asserted (registered, so visible on the following cycle).
  - If pending=1: shadow <= staging and pending <= 0.
- Load behaviour:
  - load captures the inputs into staging and sets pending.
  - Multiple loads within one frame: last wins; earlier values are never displayed.
  - load on the boundary cycle: inputs bypass straight into shadow, pending stays 0, and the new data is shown from the next frame.
- Period checks: frame period = 4*REFRESH_DIV cycles exactly. frame_done period is identical and unaffected by load.

Decomposition:
- Package sseg_pkg holds:
  - AN_OFF = 4'b1111, DP_OFF = 1'b1
  - state enum {ST_BLANK, ST_SHOW}
  - digit index typedef (2 bits)
  - NUM_DIGITS = 4
- Sub-module sseg_refresh_timer: the prescaler counter plus index. It emits slot_end, show_start and frame_end ticks, parameterised by REFRESH_DIV and BLANK_CYCLES.
- The top module holds the staging/shadow registers and output registers.

Test Plan:
- Reset check (REFRESH_DIV=8, BLANK_CYCLES=2): assert rst_n=0 mid-ST_SHOW -> an=1111, dp=1, hex=0, frame_done=0 immediately, without waiting for a clock edge. Release -> first frame_done pulse exactly 32 cycles later.
- Basic scan: load value=16'h1A2F, digit_en=1111, dp_in=0000 before first boundary. In the following frame, each slot shows an=1111 for 2 cycles, then 6 cycles of:
  - slot 0: an=1110, hex=F
  - slot 1: an=1101, hex=2
  - slot 2: an=1011, hex=A
  - slot 3: an=0111, hex=1
- Digit enable: digit_en=0101 -> slots 1 and 3 keep an=1111 for all 8 cycles while hex still shows the nibble; slots 0 and 2 scan normally.
- Tear-free update: load 16'h1111, then 16'h2222 within one frame -> next frame shows 2222 on all digits; 1 never appears on hex during ST_SHOW.
- Boundary collision: load 16'h3C3C on the slot-3 final cycle -> the very next frame shows C,3,C,3; pending remains 0, so the next boundary makes no change.
- Decimal point: dp_in=1000 -> dp=0 only during the 6 ST_SHOW cycles of slot 3 (an=0111), otherwise 1; frame_done pulses every 32 cycles throughout.
